centroid_update_ctrl: RTL and testbench
=======================================

CENTROID_UPDATE_CTRL -- requirements
Module: centroid_update_ctrl

Interface
REQ-001 SHALL have parameters: SizeOfAcc, 24, per-colour accumulator width; SizeOfCount, 12, per-engine pixel count width; NumOfEngines, 2, engines summed by the reduction unit; NumOfClusters, 4, clusters K (>=2).
REQ-002 SHALL derive SW = SizeOfAcc+NumOfEngines, CW = SizeOfCount+NumOfEngines, KW = clog2(NumOfClusters).
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low.
- start  in  1  one-cycle pulse; begins one centroid-update pass.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at the end of a pass.
- cluster_sel  out  KW  cluster whose accumulators the engines present to the sum unit.
- sum_clear  out  1  active-high synchronous clear to the sum unit.
- red_sum, green_sum, blue_sum  in  SW each  reduced colour sums.
- co_sum  in  CW  reduced pixel count.
- sum_done  in  1  high when the sum unit's outputs are final.
- cent_valid  out  1  new centroid available.
- cent_ready  in  1  consumer accepts it; transfer when valid && ready.
- cent_idx  out  KW  cluster index of the centroid.
- cent_red, cent_green, cent_blue  out  8 each  mean colour.
- cent_keep  out  1  cluster empty; consumer keeps the old centroid.

Function
REQ-005 SHALL have states IDLE, CLEAR, WAIT, LOAD, DIV, OUT, FINISH.
REQ-006 IDLE: start=1 -> CLEAR with k=0; start SHALL be ignored in every other state.
REQ-007 CLEAR: sum_clear=1 for exactly one cycle -> WAIT.
REQ-008 WAIT: sum_done=1 -> LOAD; otherwise stay in WAIT, with no timeout.
REQ-009 cluster_sel SHALL equal k and stay stable from CLEAR through LOAD.
REQ-010 LOAD: register the four sums, 1 cycle -> DIV; if co_sum==0 go directly to OUT with cent_keep=1 and RGB outputs 0.
REQ-011 DIV: floor(sum/co_sum) for red, green and blue in parallel, restoring division, one quotient bit per cycle, MSB first, exactly 8 cycles -> OUT.
REQ-012 Saturation: if sum >= 256*co_sum for a colour, that colour's result SHALL be 255.
REQ-013 OUT: cent_valid=1; cent_idx, RGB and cent_keep stay stable while cent_ready=0.
REQ-014 OUT transfer: on transfer, k<K-1 -> k+1, CLEAR; k==K-1 -> FINISH.
REQ-015 FINISH: done=1 for one cycle -> IDLE.
REQ-016 Latency per non-empty cluster: 1 (CLEAR) + WAIT + 1 (LOAD) + 8 (DIV) + OUT cycles.
REQ-017 The index counter k SHALL wrap to 0 in IDLE.
REQ-018 cent_valid SHALL be registered; a transfer and a state change never occur in the same cycle as a start.

Reset
REQ-019 reset=0 SHALL immediately force: state IDLE, k=0, busy=0, done=0, sum_clear=0, cent_valid=0, cent_keep=0, cluster_sel=0, cent_idx=0, RGB=0, and all quotient and remainder registers 0.
REQ-020 Reset in any state, including mid-DIV or OUT with valid held, SHALL abandon the pass with no further transfer; the next start begins at k=0.
REQ-021 Reset release SHALL be synchronised; the first state change occurs no earlier than the second rising edge after deassertion.

Structure
REQ-022 The state encoding, the clog2 function and the 8-bit colour width SHALL live in the shared k-means package.
REQ-023 The design SHALL contain one sub-module, serial_divider (SW/CW, 8-bit quotient, start/busy), instantiated three times.

Verification
REQ-024 Sums R=1000, G=500, B=0, count=10 on cluster 0 -> cent_idx=0, RGB=100,50,0, cent_keep=0.
REQ-025 count=0 on cluster 2 -> cent_valid with cent_idx=2, cent_keep=1, RGB=0; the DIV state is skipped (fewer cycles).
REQ-026 cent_ready held low 5 cycles in OUT -> outputs unchanged for all 5 cycles; one transfer on release; exactly K transfers, then one done pulse.
REQ-027 count=8190, R=255*8190, G=1 -> 255, 0; and R=300, count=1 -> 255 (saturated).
REQ-028 reset low during cycle 4 of DIV -> all outputs 0 immediately; a new start completes a full K-cluster pass from k=0.
REQ-029 start pulsed in WAIT and OUT -> no effect; exactly one done per pass.

Source files
------------

// File: rtl/centroid_update_ctrl_pkg.sv
// Shared k-means definitions: controller state encoding, colour width and clog2.
package centroid_update_ctrl_pkg;

    localparam int unsigned ColorW = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WAIT,
        LOAD,
        DIV,
        OUT,
        FINISH
    } state_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/centroid_update_ctrl_serial.sv
// Restoring serial divider: 8-bit quotient, one bit per cycle MSB first, saturating to 255.
module serial_divider
    import centroid_update_ctrl_pkg::*;
#(
    parameter int unsigned DividendW = 26,
    parameter int unsigned DivisorW  = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DividendW-1:0] dividend,
    input  logic [DivisorW-1:0]  divisor,
    output logic [ColorW-1:0]    quotient,
    output logic                 busy
);

    localparam int unsigned MW   = (DividendW > DivisorW + ColorW) ? DividendW : DivisorW + ColorW;
    localparam int unsigned CntW = clog2(ColorW);
    localparam logic [CntW-1:0] LastStep = CntW'(ColorW - 1);

    logic [MW-1:0]     rem;
    logic [MW-1:0]     dvs;
    logic [ColorW-1:0] quo;
    logic [CntW-1:0]   cnt;
    logic              run;
    logic              sat;
    logic [MW-1:0]     wide_dividend;
    logic [MW-1:0]     wide_limit;

    assign wide_dividend = MW'(dividend);
    assign wide_limit    = MW'(divisor) << ColorW;
    assign quotient      = quo;
    // busy drops during the final step so the controller leaves on the edge the last bit lands
    assign busy          = run && (cnt != LastStep);

    // Load operands on start, then trial-subtract the shifted divisor once per cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem <= '0;
            dvs <= '0;
            quo <= '0;
            cnt <= '0;
            run <= 1'b0;
            sat <= 1'b0;
        end else if (start) begin
            rem <= wide_dividend;
            dvs <= MW'(divisor) << (ColorW - 1);
            sat <= (wide_dividend >= wide_limit);
            quo <= '0;
            cnt <= '0;
            run <= 1'b1;
        end else if (run) begin
            if (sat) begin
                quo <= {quo[ColorW-2:0], 1'b1};
            end else if (rem >= dvs) begin
                rem <= rem - dvs;
                quo <= {quo[ColorW-2:0], 1'b1};
            end else begin
                quo <= {quo[ColorW-2:0], 1'b0};
            end
            dvs <= dvs >> 1;
            cnt <= cnt + 1'b1;
            if (cnt == LastStep) begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/centroid_update_ctrl.sv
// Centroid update controller: walks K clusters, divides reduced colour sums by pixel count.
module centroid_update_ctrl
    import centroid_update_ctrl_pkg::*;
#(
    parameter int unsigned SizeOfAcc     = 24,
    parameter int unsigned SizeOfCount   = 12,
    parameter int unsigned NumOfEngines  = 2,
    parameter int unsigned NumOfClusters = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    output logic                                 busy,
    output logic                                 done,
    output logic [clog2(NumOfClusters)-1:0]      cluster_sel,
    output logic                                 sum_clear,
    input  logic [SizeOfAcc+NumOfEngines-1:0]    red_sum,
    input  logic [SizeOfAcc+NumOfEngines-1:0]    green_sum,
    input  logic [SizeOfAcc+NumOfEngines-1:0]    blue_sum,
    input  logic [SizeOfCount+NumOfEngines-1:0]  co_sum,
    input  logic                                 sum_done,
    output logic                                 cent_valid,
    input  logic                                 cent_ready,
    output logic [clog2(NumOfClusters)-1:0]      cent_idx,
    output logic [ColorW-1:0]                    cent_red,
    output logic [ColorW-1:0]                    cent_green,
    output logic [ColorW-1:0]                    cent_blue,
    output logic                                 cent_keep
);

    localparam int unsigned SW = SizeOfAcc + NumOfEngines;
    localparam int unsigned CW = SizeOfCount + NumOfEngines;
    localparam int unsigned KW = clog2(NumOfClusters);
    localparam logic [KW-1:0] LastK = KW'(NumOfClusters - 1);

    state_t            state;
    state_t            state_next;
    logic [KW-1:0]     k;
    logic [KW-1:0]     idx_r;
    logic              keep_r;
    logic              valid_r;
    logic [1:0]        rst_sync;
    logic              run_en;
    logic              div_start;
    logic [2:0]        div_busy;
    logic              transfer;
    logic [ColorW-1:0] quo_red;
    logic [ColorW-1:0] quo_green;
    logic [ColorW-1:0] quo_blue;

    assign run_en      = rst_sync[1];
    assign transfer    = valid_r && cent_ready;
    assign cluster_sel = k;
    assign cent_valid  = valid_r;
    assign cent_idx    = idx_r;
    assign cent_keep   = keep_r;
    assign cent_red    = keep_r ? '0 : quo_red;
    assign cent_green  = keep_r ? '0 : quo_green;
    assign cent_blue   = keep_r ? '0 : quo_blue;

    // Reset release synchroniser; assertion still acts asynchronously everywhere
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    // Next-state and decoded control outputs
    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = 1'b0;
        sum_clear  = 1'b0;
        div_start  = 1'b0;
        case (state)
            IDLE:   if (start && run_en) state_next = CLEAR;
            CLEAR: begin
                sum_clear  = 1'b1;
                state_next = WAIT;
            end
            WAIT:   if (sum_done) state_next = LOAD;
            LOAD: begin
                if (co_sum == '0) begin
                    state_next = OUT;
                end else begin
                    div_start  = 1'b1;
                    state_next = DIV;
                end
            end
            DIV:    if (div_busy == '0) state_next = OUT;
            OUT:    if (transfer) state_next = (k == LastK) ? FINISH : CLEAR;
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, cluster counter and registered centroid handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            k       <= '0;
            idx_r   <= '0;
            keep_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state   <= state_next;
            valid_r <= (state_next == OUT);
            case (state)
                IDLE: k <= '0;
                LOAD: begin
                    idx_r  <= k;
                    keep_r <= (co_sum == '0);
                end
                OUT: if (transfer && k != LastK) k <= k + 1'b1;
                default: ;
            endcase
        end
    end

    serial_divider #(.DividendW(SW), .DivisorW(CW)) u_div_red (
        .clk(clk), .reset(reset), .start(div_start), .dividend(red_sum),
        .divisor(co_sum), .quotient(quo_red), .busy(div_busy[0])
    );

    serial_divider #(.DividendW(SW), .DivisorW(CW)) u_div_green (
        .clk(clk), .reset(reset), .start(div_start), .dividend(green_sum),
        .divisor(co_sum), .quotient(quo_green), .busy(div_busy[1])
    );

    serial_divider #(.DividendW(SW), .DivisorW(CW)) u_div_blue (
        .clk(clk), .reset(reset), .start(div_start), .dividend(blue_sum),
        .divisor(co_sum), .quotient(quo_blue), .busy(div_busy[2])
    );

endmodule

// File: tb/tb_centroid_update_ctrl.sv
// Directed table-driven bench for centroid_update_ctrl with a hand-modelled sum unit.
module tb_centroid_update_ctrl;

    localparam int SW = 26;
    localparam int CW = 14;
    localparam int KW = 2;

    typedef struct {
        int r;
        int g;
        int b;
        int cnt;
        int wait_cyc;
        int hold;
        int er;
        int eg;
        int eb;
        int ekeep;
    } vec_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic [KW-1:0] cluster_sel;
    logic          sum_clear;
    logic [SW-1:0] red_sum;
    logic [SW-1:0] green_sum;
    logic [SW-1:0] blue_sum;
    logic [CW-1:0] co_sum;
    logic          sum_done;
    logic          cent_valid;
    logic          cent_ready;
    logic [KW-1:0] cent_idx;
    logic [7:0]    cent_red;
    logic [7:0]    cent_green;
    logic [7:0]    cent_blue;
    logic          cent_keep;

    int   n_checks;
    int   n_errors;
    int   done_cnt;
    vec_t tbl[8];

    centroid_update_ctrl #(
        .SizeOfAcc(24), .SizeOfCount(12), .NumOfEngines(2), .NumOfClusters(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .cluster_sel(cluster_sel), .sum_clear(sum_clear),
        .red_sum(red_sum), .green_sum(green_sum), .blue_sum(blue_sum),
        .co_sum(co_sum), .sum_done(sum_done),
        .cent_valid(cent_valid), .cent_ready(cent_ready), .cent_idx(cent_idx),
        .cent_red(cent_red), .cent_green(cent_green), .cent_blue(cent_blue),
        .cent_keep(cent_keep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses away from the active edge
    always @(negedge clk) begin
        if (reset === 1'b1 && done === 1'b1) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_sum_clear"}, sum_clear, 0);
        chk({tag, "_valid"}, cent_valid, 0);
        chk({tag, "_keep"}, cent_keep, 0);
        chk({tag, "_cluster_sel"}, cluster_sel, 0);
        chk({tag, "_idx"}, cent_idx, 0);
        chk({tag, "_rgb"}, {8'd0, cent_red, cent_green, cent_blue}, 0);
    endtask

    task automatic chk_centroid(input string tag, input vec_t v, input int idx);
        chk({tag, "_valid"}, cent_valid, 1);
        chk({tag, "_idx"}, cent_idx, idx);
        chk({tag, "_red"}, cent_red, v.er);
        chk({tag, "_green"}, cent_green, v.eg);
        chk({tag, "_blue"}, cent_blue, v.eb);
        chk({tag, "_keep"}, cent_keep, v.ekeep);
    endtask

    // One cluster: answer the clear, present sums, collect and release the centroid
    task automatic do_cluster(input vec_t v, input int idx, input bit inject_start);
        int n;
        int cyc;
        for (n = 0; n < 40 && sum_clear !== 1'b1; n++) @(negedge clk);
        chk("sum_clear_seen", sum_clear, 1);
        chk("cluster_sel_clear", cluster_sel, idx);
        chk("busy_in_pass", busy, 1);
        @(negedge clk);
        chk("sum_clear_one_cycle", sum_clear, 0);
        for (int w = 0; w < v.wait_cyc; w++) begin
            start = (inject_start && w == 0);
            @(negedge clk);
            start = 1'b0;
            chk("cluster_sel_wait", cluster_sel, idx);
        end
        red_sum   = v.r[SW-1:0];
        green_sum = v.g[SW-1:0];
        blue_sum  = v.b[SW-1:0];
        co_sum    = v.cnt[CW-1:0];
        sum_done  = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            sum_done = 1'b0;
            cyc++;
        end while (cent_valid !== 1'b1 && cyc < 40);
        chk("latency", cyc, (v.cnt == 0) ? 2 : 10);
        chk_centroid("cent", v, idx);
        cent_ready = 1'b0;
        for (int d = 0; d < v.hold; d++) begin
            start = (inject_start && d == 1);
            @(negedge clk);
            start = 1'b0;
            chk_centroid("hold", v, idx);
        end
        cent_ready = 1'b1;
        @(negedge clk);
        cent_ready = 1'b0;
        chk("valid_drop", cent_valid, 0);
    endtask

    task automatic run_pass(input int base, input bit inject_start);
        int d0;
        d0 = done_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 4; c++) do_cluster(tbl[base + c], c, inject_start && c == 1);
        chk("done_pulse", done, 1);
        chk("busy_in_finish", busy, 1);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_after_pass", busy, 0);
        repeat (3) @(negedge clk);
        chk("one_done_per_pass", done_cnt - d0, 1);
        chk("stays_idle", busy, 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        done_cnt = 0;
        tbl[0] = '{1000, 500, 0, 10, 0, 0, 100, 50, 0, 0};
        tbl[1] = '{2088450, 1, 0, 8190, 2, 5, 255, 0, 0, 0};
        tbl[2] = '{123, 45, 6, 0, 1, 1, 0, 0, 0, 1};
        tbl[3] = '{300, 0, 1, 1, 3, 0, 255, 0, 1, 0};
        tbl[4] = '{77, 77, 77, 7, 0, 0, 11, 11, 11, 0};
        tbl[5] = '{768, 764, 2, 3, 1, 2, 255, 254, 0, 0};
        tbl[6] = '{67108863, 5, 1638300, 16383, 0, 0, 255, 0, 100, 0};
        tbl[7] = '{0, 0, 0, 0, 4, 3, 0, 0, 0, 1};

        reset = 1'b0;
        start = 1'b0;
        red_sum = '0;
        green_sum = '0;
        blue_sum = '0;
        co_sum = '0;
        sum_done = 1'b0;
        cent_ready = 1'b0;
        #3;
        chk_outputs_zero("por");
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        run_pass(0, 1'b1);

        // Abandon a pass in the fourth DIV cycle
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort_sum_clear", sum_clear, 1);
        @(negedge clk);
        red_sum = 26'd1000;
        green_sum = 26'd500;
        blue_sum = 26'd0;
        co_sum = 14'd10;
        sum_done = 1'b1;
        @(negedge clk);
        sum_done = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_in_div_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        chk_outputs_zero("mid_div_reset");
        repeat (3) @(negedge clk);
        chk_outputs_zero("held_reset");
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_ignored_during_sync", busy, 0);
        repeat (2) @(negedge clk);
        chk("still_idle_after_sync", busy, 0);

        run_pass(4, 1'b0);
        chk("total_done_pulses", done_cnt, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
